flappy_engine: RTL and testbench
================================

# flappy_engine

Parametrised game core for the Flappy Bird VGA design. It owns N pipe lanes with internal scrolling and respawn, plus an IDLE/RUN/DEAD game state machine with a dead-time timer. It also does bird/pipe/floor/ceiling collision, a saturating score with a high score, and registered per-pixel RGB generation. It sits between the clock divider (game `tick`), the bird position module (`bird_y`), the random source and the VGA sync/colour outputs.

## Interface
- `N_PIPES`, 3: number of pipe lanes.
- `BIRD_X`, 100: bird left column.
- `BIRD_SIZE`, 30: bird square side.
- `PIPE_W`, 40: pipe width.
- `GAP_HALF`, 70: half height of the pipe gap.
- `PIPE_SPACING`, 240: horizontal lane spacing. Constraint: N_PIPES*PIPE_SPACING ≥ SCREEN_W+PIPE_W and < 2048.
- `SCREEN_W` / `SCREEN_H`, 640 / 480: visible area.
- `SCORE_W`, 7: score width.
- `DEAD_TICKS`, 50: ticks spent in DEAD.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk` game-step strobe.
- `btn_pressed` in 1: level input, synchronous to `clk`.
- `bird_y` in 10: bird bottom edge. The bird occupies rows [bird_y-BIRD_SIZE, bird_y).
- `rand_in` in 4: random value, sampled on respawn.
- `x_crd`, `y_crd` in 10 each: current pixel.
- `red_ch`, `green_ch`, `blue_ch` out 1 each: registered pixel colour.
- `score_out` out SCORE_W: current score.
- `hiscore_out` out SCORE_W: best score since reset.
- `state_out` out 2: IDLE=0, RUN=1, DEAD=2.

## Operation
- Reset values:
  - state IDLE; score 0; hiscore 0; dead timer 0; RGB 0; button edge register 0.
  - Lane i: x = SCREEN_W + i*PIPE_SPACING (11-bit); gap centre = 240.
- Lane x is the pipe's right edge (exclusive). The pipe covers columns [x-PIPE_W, x), clamped at 0. Comparisons use 11 bits (x_crd+PIPE_W ≥ x form), so no underflow is possible.
- IDLE:
  - Pipes stay frozen.
  - A rising edge of `btn_pressed` moves to RUN on the next `clk` and clears the score in the same edge.
  - `tick` is irrelevant to this transition.
- RUN, on each `tick`:
  1. Collision is evaluated on the pre-move lane positions.
  2. If there is no collision, every lane decrements x by 1.
  3. A lane decremented to 0 respawns at x = N_PIPES*PIPE_SPACING with gap centre = 160 + 16*rand_in (range 160..400).
  4. Score increments for each lane that moves from BIRD_X to BIRD_X-1, saturating at 2^SCORE_W-1.
  - Button edges are ignored (flap physics lives outside this block).
- Collision is the OR of the following:
  - any lane whose column range overlaps [BIRD_X, BIRD_X+BIRD_SIZE) while the bird rows extend outside [gy-GAP_HALF, gy+GAP_HALF);
  - bird_y ≥ SCREEN_H;
  - bird_y < BIRD_SIZE.
- On collision:
  - The state becomes DEAD and the lanes do not move on that tick.
  - hiscore ← max(hiscore, score) in the same edge.
  - The timer loads DEAD_TICKS.
- DEAD:
  - Lanes freeze and score holds.
  - The timer decrements per `tick`. When it hits 0 the state goes to IDLE and the lanes reload their reset positions.
  - Button input is ignored.
- Pixel colour:
  - Lane i pipe area → colour by i mod 3: red, red+green, red+blue.
  - Bird area → green in IDLE/RUN, red in DEAD.
  - Bird and pipe colours are ORed.
- `rst` mid-operation returns everything to the reset values immediately.

## Timing
- RGB outputs have a 1-`clk` latency from `x_crd`/`y_crd` and use the lane/bird state present at that edge.
- State, score and lane updates occur on the `clk` edge where `tick`=1.
- `score_out`, `hiscore_out` and `state_out` are direct register outputs, with 0 cycles of combinational logic.
- The button edge detector has one register stage. IDLE→RUN happens on the edge after the rising edge is seen.
- A simultaneous collision and score-crossing on the same tick gives collision priority: no score increment.

## Structure
- `flappy_pkg`: state encoding, SCREEN_W/SCREEN_H defaults, colour index constants.
- Sub-module `pipe_lane`, instantiated N_PIPES times in a generate loop:
  - holds x and gap centre;
  - performs move/respawn/reload;
  - outputs hit, score-cross and pixel-in-pipe flags.
- The top level keeps the FSM, timer, score, hiscore, OR-reductions and output registers.

## Test plan
- Reset, then idle for 1000 ticks → state_out=0; lane xs stay 640/880/1120; RGB=0.
- Button edge, then 541 ticks with bird_y=260 → score_out=1 after tick 541; state_out=1.
- Button edge, then bird_y=150 → collision on tick 472 (lane0 x=169); state_out=2 one clk later; hiscore_out=0; lane0 stays at 169.
- RUN with bird_y=480 → DEAD on the next tick. After 50 ticks: state_out=0 and lane0 x=640.
- Pixel checks in IDLE with bird_y=260:
  - x=620, y=100 → red_ch=1 one clk later;
  - x=110, y=250 → green_ch=1;
  - x=620, y=240 → all 0.
- Long run with rand_in=15 and SCORE_W=3 forced → score saturates at 7; respawned gap centre = 400; `rst` mid-RUN clears all.

Source files
------------

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared state encoding, screen defaults and colour constants for flappy_engine
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // RGB packed as {red, green, blue}
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_MAGENTA = 3'b101;

    localparam logic [9:0] GAP_RST  = 10'd240;
    localparam logic [9:0] GAP_BASE = 10'd160;

    function automatic logic [2:0] lane_colour(input int idx);
        case (idx % 3)
            0:       return COL_RED;
            1:       return COL_YELLOW;
            default: return COL_MAGENTA;
        endcase
    endfunction

endpackage

// File: rtl/pipe_lane.sv
// rtl/pipe_lane.sv - one scrolling pipe lane: position, gap centre, hit/score/pixel flags
module pipe_lane
    import flappy_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int N_PIPES      = 3,
    parameter int BIRD_X       = 100,
    parameter int BIRD_SIZE    = 30,
    parameter int PIPE_W       = 40,
    parameter int GAP_HALF     = 70,
    parameter int PIPE_SPACING = 240,
    parameter int SCREEN_W     = SCREEN_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move,
    input  logic       reload,
    input  logic [9:0] bird_y,
    input  logic [3:0] rand_in,
    input  logic [9:0] x_crd,
    input  logic [9:0] y_crd,
    output logic       hit,
    output logic       score_cross,
    output logic       pix
);

    localparam logic [10:0] X_RST     = 11'(SCREEN_W + IDX * PIPE_SPACING);
    localparam logic [10:0] X_RESPAWN = 11'(N_PIPES * PIPE_SPACING);

    logic [10:0] x_q, x_d;
    logic [9:0]  gy_q, gy_d;

    logic [10:0] by, gy, xc, yc;
    logic        col_ovl, bird_out;

    always_comb begin
        x_d  = x_q;
        gy_d = gy_q;
        if (reload) begin
            x_d  = X_RST;
            gy_d = GAP_RST;
        end else if (move) begin
            if (x_q == 11'd1) begin
                x_d  = X_RESPAWN;
                gy_d = GAP_BASE + {2'b00, rand_in, 4'b0000};
            end else begin
                x_d = x_q - 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= X_RST;
            gy_q <= GAP_RST;
        end else begin
            x_q  <= x_d;
            gy_q <= gy_d;
        end
    end

    // All comparisons are rearranged into additions so nothing underflows
    always_comb begin
        by = {1'b0, bird_y};
        gy = {1'b0, gy_q};
        xc = {1'b0, x_crd};
        yc = {1'b0, y_crd};

        col_ovl  = (x_q > 11'(BIRD_X)) && (x_q < 11'(BIRD_X + BIRD_SIZE + PIPE_W));
        bird_out = (by + 11'(GAP_HALF) < gy + 11'(BIRD_SIZE)) || (by > gy + 11'(GAP_HALF));
        hit      = col_ovl && bird_out;

        score_cross = (x_q == 11'(BIRD_X));

        pix = (xc < x_q) && (xc + 11'(PIPE_W) >= x_q)
              && ((yc + 11'(GAP_HALF) < gy) || (yc >= gy + 11'(GAP_HALF)));
    end

endmodule

// File: rtl/flappy_engine.sv
// rtl/flappy_engine.sv - game core: state machine, dead timer, score/hiscore, lanes and pixel colour
module flappy_engine
    import flappy_pkg::*;
#(
    parameter int N_PIPES      = 3,
    parameter int BIRD_X       = 100,
    parameter int BIRD_SIZE    = 30,
    parameter int PIPE_W       = 40,
    parameter int GAP_HALF     = 70,
    parameter int PIPE_SPACING = 240,
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int SCORE_W      = 7,
    parameter int DEAD_TICKS   = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               btn_pressed,
    input  logic [9:0]         bird_y,
    input  logic [3:0]         rand_in,
    input  logic [9:0]         x_crd,
    input  logic [9:0]         y_crd,
    output logic               red_ch,
    output logic               green_ch,
    output logic               blue_ch,
    output logic [SCORE_W-1:0] score_out,
    output logic [SCORE_W-1:0] hiscore_out,
    output logic [1:0]         state_out
);

    localparam int                 TW        = $clog2(DEAD_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               btn_q;
    logic [2:0]         rgb_q, rgb_d;

    logic [N_PIPES-1:0] hit, score_cross, pix;
    logic               btn_edge, collide, move, reload, bird_pix;
    logic [10:0]        by, xc, yc;

    for (genvar i = 0; i < N_PIPES; i++) begin : g_lane
        pipe_lane #(
            .IDX          (i),
            .N_PIPES      (N_PIPES),
            .BIRD_X       (BIRD_X),
            .BIRD_SIZE    (BIRD_SIZE),
            .PIPE_W       (PIPE_W),
            .GAP_HALF     (GAP_HALF),
            .PIPE_SPACING (PIPE_SPACING),
            .SCREEN_W     (SCREEN_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .move        (move),
            .reload      (reload),
            .bird_y      (bird_y),
            .rand_in     (rand_in),
            .x_crd       (x_crd),
            .y_crd       (y_crd),
            .hit         (hit[i]),
            .score_cross (score_cross[i]),
            .pix         (pix[i])
        );
    end

    assign btn_edge = btn_pressed & ~btn_q;
    assign by       = {1'b0, bird_y};
    assign xc       = {1'b0, x_crd};
    assign yc       = {1'b0, y_crd};
    assign collide  = (|hit) || (by >= 11'(SCREEN_H)) || (by < 11'(BIRD_SIZE));

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        timer_d   = timer_q;
        move      = 1'b0;
        reload    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_edge) begin
                    state_d = ST_RUN;
                    score_d = '0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    // Collision wins over any score crossing on the same tick
                    if (collide) begin
                        state_d   = ST_DEAD;
                        hiscore_d = (score_q > hiscore_q) ? score_q : hiscore_q;
                        timer_d   = TW'(DEAD_TICKS);
                    end else begin
                        move = 1'b1;
                        for (int i = 0; i < N_PIPES; i++) begin
                            if (score_cross[i] && score_d != SCORE_MAX) begin
                                score_d = score_d + SCORE_W'(1);
                            end
                        end
                    end
                end
            end
            ST_DEAD: begin
                if (tick) begin
                    if (timer_q <= TW'(1)) begin
                        timer_d = '0;
                        state_d = ST_IDLE;
                        reload  = 1'b1;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bird_pix = (xc >= 11'(BIRD_X)) && (xc < 11'(BIRD_X + BIRD_SIZE))
                   && (yc < by) && (yc + 11'(BIRD_SIZE) >= by);
        rgb_d = 3'b000;
        for (int i = 0; i < N_PIPES; i++) begin
            if (pix[i]) begin
                rgb_d = rgb_d | lane_colour(i);
            end
        end
        if (bird_pix) begin
            rgb_d = rgb_d | ((state_q == ST_DEAD) ? COL_RED : COL_GREEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            hiscore_q <= '0;
            timer_q   <= '0;
            btn_q     <= 1'b0;
            rgb_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            timer_q   <= timer_d;
            btn_q     <= btn_pressed;
            rgb_q     <= rgb_d;
        end
    end

    assign red_ch      = rgb_q[2];
    assign green_ch    = rgb_q[1];
    assign blue_ch     = rgb_q[0];
    assign score_out   = score_q;
    assign hiscore_out = hiscore_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_flappy_engine.sv
// tb/tb_flappy_engine.sv - directed self-checking bench for flappy_engine
module tb_flappy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn;
    logic [9:0] bird_y;
    logic [3:0] rand_in;
    logic [9:0] x_crd, y_crd;

    logic       red, green, blue;
    logic [6:0] score, hiscore;
    logic [1:0] st;

    logic       red3, green3, blue3;
    logic [2:0] score3, hiscore3;
    logic [1:0] st3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flappy_engine dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_pressed (btn),
        .bird_y      (bird_y),
        .rand_in     (rand_in),
        .x_crd       (x_crd),
        .y_crd       (y_crd),
        .red_ch      (red),
        .green_ch    (green),
        .blue_ch     (blue),
        .score_out   (score),
        .hiscore_out (hiscore),
        .state_out   (st)
    );

    flappy_engine #(.SCORE_W(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_pressed (btn),
        .bird_y      (bird_y),
        .rand_in     (rand_in),
        .x_crd       (x_crd),
        .y_crd       (y_crd),
        .red_ch      (red3),
        .green_ch    (green3),
        .blue_ch     (blue3),
        .score_out   (score3),
        .hiscore_out (hiscore3),
        .state_out   (st3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic pix_check(input string tag, input int px, input int py, input logic [2:0] exp);
        @(negedge clk);
        x_crd = 10'(px);
        y_crd = 10'(py);
        @(negedge clk);
        check(tag, {29'd0, red, green, blue}, {29'd0, exp});
    endtask

    task automatic press(input string tag);
        @(negedge clk) btn = 1'b0;
        @(negedge clk) btn = 1'b1;
        @(negedge clk);
        check(tag, st, 1);
        check({tag, "_score"}, score, 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; btn = 1'b0; bird_y = 10'd260;
        rand_in = 4'd0; x_crd = 10'd0; y_crd = 10'd0;
        repeat (3) @(negedge clk);
        check("rst_state", st, 0);
        check("rst_score", score, 0);
        check("rst_hiscore", hiscore, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_lane0", dut.g_lane[0].u_lane.x_q, 640);
        check("rst_lane1", dut.g_lane[1].u_lane.x_q, 880);
        check("rst_lane2", dut.g_lane[2].u_lane.x_q, 1120);
        check("rst_gap0", dut.g_lane[0].u_lane.gy_q, 240);
        rst = 1'b0;

        tick_n(1000);
        check("idle_state", st, 0);
        check("idle_lane0", dut.g_lane[0].u_lane.x_q, 640);
        check("idle_lane1", dut.g_lane[1].u_lane.x_q, 880);
        check("idle_lane2", dut.g_lane[2].u_lane.x_q, 1120);
        check("idle_rgb", {red, green, blue}, 0);

        pix_check("pix_pipe0", 620, 100, 3'b100);
        pix_check("pix_bird", 110, 250, 3'b010);
        pix_check("pix_gap", 620, 240, 3'b000);
        pix_check("pix_pipe0_left", 600, 100, 3'b100);
        pix_check("pix_pipe0_right", 639, 460, 3'b100);
        pix_check("pix_pipe0_past", 640, 100, 3'b000);
        pix_check("pix_pipe1", 850, 100, 3'b110);
        pix_check("pix_gap_edge", 620, 310, 3'b100);

        // Fresh run: bird low in the gap, lane 0 hits at its 472nd tick
        press("run1");
        bird_y = 10'd150;
        tick_n(471);
        check("pre_hit_state", st, 1);
        check("pre_hit_lane0", dut.g_lane[0].u_lane.x_q, 169);
        tick_n(1);
        check("hit_state", st, 2);
        check("hit_lane0", dut.g_lane[0].u_lane.x_q, 169);
        check("hit_hiscore", hiscore, 0);
        tick_n(49);
        check("dead49_state", st, 2);
        check("dead49_lane0", dut.g_lane[0].u_lane.x_q, 169);
        tick_n(1);
        check("dead50_state", st, 0);
        check("dead50_lane0", dut.g_lane[0].u_lane.x_q, 640);

        bird_y = 10'd260;
        press("run2");
        tick_n(540);
        check("score_540", score, 0);
        tick_n(1);
        check("score_541", score, 1);
        check("run2_state", st, 1);
        check("run2_lane0", dut.g_lane[0].u_lane.x_q, 99);

        bird_y = 10'd480;
        tick_n(1);
        check("floor_state", st, 2);
        check("floor_hiscore", hiscore, 1);
        check("floor_lane0", dut.g_lane[0].u_lane.x_q, 99);
        pix_check("pix_bird_dead", 110, 470, 3'b100);
        tick_n(49);
        check("floor_dead49", st, 2);
        tick_n(1);
        check("floor_idle", st, 0);
        check("floor_lane0_rst", dut.g_lane[0].u_lane.x_q, 640);
        check("idle_score_hold", score, 1);

        // Long run: respawned gaps sit at 400, bird follows once old gaps are gone
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("long_rst_hiscore", hiscore, 0);
        rand_in = 4'd15;
        bird_y  = 10'd260;
        press("run3");
        tick_n(1100);
        bird_y = 10'd400;
        tick_n(1200);
        check("long_state", st, 1);
        check("long_state3", st3, 1);
        check("long_score", score, 8);
        check("long_score_sat", score3, 7);
        check("long_lane0", dut3.g_lane[0].u_lane.x_q, 500);
        check("long_gap0", dut3.g_lane[0].u_lane.gy_q, 400);
        pix_check("long_bird", 110, 380, 3'b010);

        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_state", st, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_score3", score3, 0);
        check("mid_rst_rgb", {red, green, blue}, 0);
        check("mid_rst_lane0", dut.g_lane[0].u_lane.x_q, 640);
        check("mid_rst_gap0", dut.g_lane[0].u_lane.gy_q, 240);
        @(negedge clk) rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
